// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory command encodings, branch redirect modes
// and the fetch-stage state encoding.
package cpu_pkg;

  localparam logic [1:0] MWRITE = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MNONE  = 2'b10;

  typedef enum logic {
    BR_REL = 1'b0,
    BR_ABS = 1'b1
  } redirect_mode_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Small circular prefetch buffer. Head entry is presented combinationally so
// decode sees a word in the same cycle it becomes the oldest entry. Clear
// wins over push so a redirect or halt drops the word arriving that cycle.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 25,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             wr_en;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wr_en = push & ~clear & ~reset;

  // One write port per entry; each entry only loads when the write pointer selects it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (wr_en && (wr_ptr_q == PTR_W'(gi))) begin
        mem_q[gi] <= wr_data;
      end
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keeps the count.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, issues one-cycle-latency
// memory reads, buffers returned words in a prefetch queue and hands them to
// decode with a valid/ready handshake. Supports relative/absolute redirects
// and a sticky halt that only reset clears.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 9,
  parameter int              INSTR_W  = 16,
  parameter int              DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [1:0]         mem_cmd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] read_data,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               id_ready,
  input  logic               redirect_en,
  input  logic               redirect_mode,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic [ADDR_W-1:0]  redirect_val,
  input  logic               halt_req,
  output logic               halted
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = INSTR_W + ADDR_W;

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic               pending_q;
  logic [ADDR_W-1:0]  pending_pc_q;

  logic               run;
  logic               redirect_take;
  logic               issue;
  logic               push;
  logic               pop;
  logic               q_clear;
  logic [CNT_W-1:0]   q_count;
  logic [ENTRY_W-1:0] q_head;
  logic [CNT_W:0]     occ_after;

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .clear   (q_clear),
    .wr_data ({read_data, pending_pc_q}),
    .head    (q_head),
    .count   (q_count)
  );

  // Handshake, issue and queue control; reset > halt > redirect > normal.
  always_comb begin
    run           = (state_q == RUN);
    redirect_take = run & redirect_en & ~halt_req;
    q_clear       = run & (halt_req | redirect_en);
    if_valid      = (q_count != '0) & ~redirect_en & run & ~reset;
    pop           = if_valid & id_ready;
    push          = pending_q & run & ~redirect_en & ~halt_req & ~reset;
    // Space is reserved at issue time: queued + in flight - leaving this cycle.
    // pop implies q_count >= 1, so this cannot underflow.
    occ_after     = {1'b0, q_count} + {{CNT_W{1'b0}}, pending_q} - {{CNT_W{1'b0}}, pop};
    issue         = run & ~reset & ~redirect_en & ~halt_req &
                    (occ_after < (CNT_W + 1)'(DEPTH));
    mem_cmd       = issue ? MREAD : MNONE;
    mem_addr      = fetch_pc_q;
    {if_instr, if_pc} = q_head;
    halted        = (state_q == HALTED);
  end

  // Next fetch address: redirect target, sequential increment, or hold.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_take) begin
      if (redirect_mode_t'(redirect_mode) == BR_ABS) begin
        fetch_pc_d = redirect_val;
      end else begin
        fetch_pc_d = redirect_pc + ADDR_W'(1) + redirect_val;
      end
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    end
  end

  // Halt is sticky; only reset returns the stage to RUN.
  always_comb begin
    state_d = state_q;
    if (state_q == RUN && halt_req) begin
      state_d = HALTED;
    end
  end

  // State, PC and in-flight read tracking; no issue this cycle means nothing in flight next.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      fetch_pc_q   <= RESET_PC;
      pending_q    <= 1'b0;
      pending_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pending_q  <= issue;
      if (issue) begin
        pending_pc_q <= fetch_pc_q;
      end
    end
  end

endmodule
